// File: rtl/node_pkg.sv
// Shared types and constants for the node start/ready invoker.
`default_nettype none

package node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEFAULT_W        = 16;
    localparam int TIMEOUT_DISABLED = 0;

    // A disabled watchdog still needs a 1-bit counter to keep the vector legal.
    function automatic int wd_width(input int timeout);
        return (timeout == TIMEOUT_DISABLED) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/node_watchdog.sv
// Cycle counter that flags expiry after TIMEOUT enabled cycles since the last clear.
`default_nettype none

module node_watchdog
    import node_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW              = wd_width(TIMEOUT);
    localparam int LAST            = (TIMEOUT == TIMEOUT_DISABLED) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] C_LAST = CW'(LAST);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT != TIMEOUT_DISABLED) && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/node_invoker.sv
// Initiator for the node ST/RD protocol: latches operands, pulses start, captures result or timeout.
`default_nettype none

module node_invoker
    import node_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [W-1:0]     i_in_a,
    input  logic [W-1:0]     i_in_b,
    output logic             o_node_st,
    output logic [W-1:0]     o_node_in0,
    output logic [W-1:0]     o_node_in1,
    input  logic             i_node_rd,
    input  logic [W-1:0]     i_node_res,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [W-1:0]     o_out_res,
    output logic             o_out_tmo,
    output logic [CNT_W-1:0] o_done_cnt
);

    state_t           r_state;
    logic             r_node_st;
    logic [W-1:0]     r_in0;
    logic [W-1:0]     r_in1;
    logic [W-1:0]     r_res;
    logic             r_tmo;
    logic [CNT_W-1:0] r_done_cnt;

    logic w_wd_clr;
    logic w_wd_en;
    logic w_wd_expire;

    // The watchdog only advances on WAIT cycles that neither complete nor expire.
    assign w_wd_clr = (r_state == START);
    assign w_wd_en  = (r_state == WAIT) && !i_node_rd && !w_wd_expire;

    node_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_node_st  <= 1'b0;
            r_in0      <= '0;
            r_in1      <= '0;
            r_res      <= '0;
            r_tmo      <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_in0     <= i_in_a;
                        r_in1     <= i_in_b;
                        r_node_st <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    r_node_st <= 1'b0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the expiry cycle takes priority over the timeout.
                    if (i_node_rd) begin
                        r_res   <= i_node_res;
                        r_tmo   <= 1'b0;
                        r_state <= HOLD;
                    end else if (w_wd_expire) begin
                        r_res   <= '0;
                        r_tmo   <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_done_cnt <= r_done_cnt + 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_node_st <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == HOLD);
    assign o_node_st   = r_node_st;
    assign o_node_in0  = r_in0;
    assign o_node_in1  = r_in1;
    assign o_out_res   = r_res;
    assign o_out_tmo   = r_tmo;
    assign o_done_cnt  = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_node_invoker.sv
// Directed bench for node_invoker with TIMEOUT=8; node behaviour is driven step by step.
`default_nettype none

module tb_node_invoker;

    localparam int W   = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          node_st;
    logic [W-1:0]  node_in0;
    logic [W-1:0]  node_in1;
    logic          node_rd = 1'b0;
    logic [W-1:0]  node_res = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_res;
    logic          out_tmo;
    logic [15:0]   done_cnt;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_done = '0;

    always #5 clk = ~clk;

    node_invoker #(
        .W       (W),
        .TIMEOUT (TMO),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .o_node_st   (node_st),
        .o_node_in0  (node_in0),
        .o_node_in1  (node_in1),
        .i_node_rd   (node_rd),
        .i_node_res  (node_res),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_res   (out_res),
        .o_out_tmo   (out_tmo),
        .o_done_cnt  (done_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair and stop in the START cycle.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b;
        chk("in_ready_idle", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_a = ~a; in_b = ~b;
        chk("node_st_pulse", node_st, 1'b1);
        chk("node_in0", node_in0, a);
        chk("node_in1", node_in1, b);
        chk("in_ready_busy", in_ready, 1'b0);
    endtask

    // Raise RD k cycles after START (k=0: never) and check the captured result.
    task automatic wait_res(input int k, input logic [W-1:0] res,
                            input logic [W-1:0] exp_res, input logic exp_tmo);
        int lim;
        lim = (k == 0) ? TMO : k;
        for (int j = 1; j <= lim; j++) begin
            @(negedge clk);
            chk("node_st_low_wait", node_st, 1'b0);
            chk("out_valid_low_wait", out_valid, 1'b0);
            if (j == k) begin
                node_rd = 1'b1; node_res = res;
            end
        end
        @(negedge clk);
        node_rd = 1'b0; node_res = '0;
        chk("out_valid", out_valid, 1'b1);
        chk("out_res", out_res, exp_res);
        chk("out_tmo", out_tmo, exp_tmo);
        chk("node_in0_held", node_in0, ~in_a);
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_done++;
        chk("done_cnt", done_cnt, exp_done);
        chk("in_ready_after", in_ready, 1'b1);
        chk("out_valid_after", out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a, b, r;
        logic [W-1:0] hold_res;
        int           k, n;
        bit           acc, rdy;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_node_st", node_st, 1'b0);
        chk("rst_in0", node_in0, 16'h0000);
        chk("rst_in1", node_in1, 16'h0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_res", out_res, 16'h0000);
        chk("rst_out_tmo", out_tmo, 1'b0);
        chk("rst_done_cnt", done_cnt, 16'h0000);
        rst_n = 1'b1;

        // 1. Basic op, k=3, result valid accept+5
        start_op(16'h0005, 16'h0007);
        wait_res(3, 16'h000C, 16'h000C, 1'b0);

        // 2. Backpressure for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $error("FAIL bp_valid observed=%0h expected=1", out_valid);
            end
            checks++;
            if (out_res !== 16'h000C) begin
                failures++;
                $error("FAIL bp_res observed=%0h expected=c", out_res);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $error("FAIL bp_in_ready observed=%0h expected=0", in_ready);
            end
        end
        accept_out();

        // 3. Timeout: no RD, valid 9 cycles after NODE_ST, late RD in HOLD ignored
        start_op(16'h1111, 16'h2222);
        wait_res(0, 16'h0000, 16'h0000, 1'b1);
        node_rd = 1'b1; node_res = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            chk("late_rd_res", out_res, 16'h0000);
            chk("late_rd_tmo", out_tmo, 1'b1);
        end
        node_rd = 1'b0; node_res = '0;
        accept_out();

        // 4. RD on the expiry cycle wins
        start_op(16'h00AA, 16'h0055);
        wait_res(TMO, 16'hBEEF, 16'hBEEF, 1'b0);
        accept_out();

        // 5. Async reset in WAIT, stale RD ignored afterwards
        start_op(16'h0001, 16'h0002);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        node_rd = 1'b1; node_res = 16'h5A5A;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_in0", node_in0, 16'h0000);
        chk("mid_rst_node_st", node_st, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_done_cnt", done_cnt, 16'h0000);
        exp_done = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stale_rd_valid", out_valid, 1'b0);
            chk("stale_rd_in_ready", in_ready, 1'b1);
        end
        node_rd = 1'b0; node_res = '0;
        start_op(16'h0030, 16'h0004);
        wait_res(2, 16'h0034, 16'h0034, 1'b0);
        accept_out();

        // 6. Stream of 20 ops, random latency and backpressure
        for (int op = 0; op < 20; op++) begin
            a = W'($urandom);
            b = W'($urandom);
            k = $urandom_range(1, 5);
            r = a + b;
            start_op(a, b);
            wait_res(k, r, r, 1'b0);
            hold_res = out_res;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 50) begin
                rdy = 1'($urandom_range(0, 1));
                out_ready = rdy;
                @(negedge clk);
                n++;
                if (rdy) begin
                    acc = 1'b1;
                end else begin
                    checks++;
                    if (out_valid !== 1'b1) begin
                        failures++;
                        $error("FAIL stream_hold_valid observed=%0h expected=1", out_valid);
                    end
                    checks++;
                    if (out_res !== hold_res) begin
                        failures++;
                        $error("FAIL stream_hold_res observed=%0h expected=%0h", out_res, hold_res);
                    end
                    checks++;
                    if (node_st !== 1'b0) begin
                        failures++;
                        $error("FAIL stream_st_low observed=%0h expected=0", node_st);
                    end
                end
            end
            out_ready = 1'b0;
            chk("stream_accepted", acc, 1'b1);
            exp_done++;
            chk("stream_done_cnt", done_cnt, exp_done);
        end
        chk("stream_total", done_cnt, 16'd21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit");
    end

endmodule

`default_nettype wire
